conv_bram_read_arbiter: RTL and testbench

Shares the single 256-bit read port of the PS-loaded image BRAM between up to NUM_REQ convolution engines (one edge-detection/conv instance per output channel), which today each want to drive the BRAM address alone. Each engine issues column-fetch requests. The arbiter grants one per cycle, round-robin, with optional burst lock. It returns the BRAM word to the winning engine after the fixed BRAM read latency. It sits between the conv engines and the BRAM_PS port in the conv top level.

---
 rtl/conv_pkg.sv | 19 +
 rtl/conv_bram_read_arbiter_rr_priority_pick.sv | 31 +++
 rtl/conv_bram_read_arbiter.sv | 120 ++++++++++++
 tb/tb_conv_bram_read_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the conv top level: BRAM_PS geometry defaults and
// the read-arbiter state encoding.
package conv_pkg;

  localparam int CONV_ADDR_WIDTH = 12;
  localparam int CONV_DATA_WIDTH = 256;
  localparam int CONV_RD_LATENCY = 2;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Modulo-n increment for round-robin pointers.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/conv_bram_read_arbiter_rr_priority_pick.sv
// Combinational round-robin picker: first set bit of req scanning upward
// from rr_ptr with wrap-around. Returns the one-hot grant and its index.
module rr_priority_pick #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] idx
);

  logic found;
  int   pos;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(rr_ptr) + k) % N;
      if (!found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
        idx      = PTR_W'(pos);
      end
    end
  end

endmodule

// File: rtl/conv_bram_read_arbiter.sv
// Shares the single BRAM_PS read port between NUM_REQ conv engines with
// round-robin grants, optional burst lock and a latency-matched return path.
module conv_bram_read_arbiter
  import conv_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = CONV_ADDR_WIDTH,
  parameter int DATA_WIDTH = CONV_DATA_WIDTH,
  parameter int RD_LATENCY = CONV_RD_LATENCY
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rd_valid,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic [ADDR_WIDTH-1:0]         bram_addr,
  output logic                          bram_en,
  input  logic [DATA_WIDTH-1:0]         bram_dout,
  output logic                          busy
);

  localparam int PTR_W = $clog2(NUM_REQ);

  // Handshake: engine i holds req[i] and its address slice stable until it
  // sees gnt[i] in the same cycle; req[i] & gnt[i] is the accept. Exactly one
  // rd_valid[i] pulse follows each accept RD_LATENCY cycles later, with no
  // backpressure.

  arb_state_t         state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   owner;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [PTR_W-1:0]   pick_idx;
  logic [PTR_W-1:0]   gnt_idx;
  logic               accept;
  logic               in_flight;
  logic [NUM_REQ-1:0] pipe [RD_LATENCY];

  rr_priority_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .gnt    (pick_gnt),
    .idx    (pick_idx)
  );

  // Grants are suppressed while rst is high so nothing reaches the BRAM.
  always_comb begin
    gnt     = '0;
    gnt_idx = pick_idx;
    if (!rst) begin
      if (state == LOCKED) begin
        gnt_idx    = owner;
        gnt[owner] = req[owner];
      end else begin
        gnt = pick_gnt;
      end
    end
  end

  assign accept    = |(req & gnt);
  assign bram_en   = accept;
  assign bram_addr = accept ? req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH] : '0;

  // A synchronous reset cannot clear the last stage until the edge, so the
  // output is masked during rst to discard any read already in flight.
  assign rd_valid = rst ? '0 : pipe[RD_LATENCY-1];
  assign rd_data  = bram_dout;

  always_comb begin
    in_flight = 1'b0;
    for (int s = 0; s < RD_LATENCY; s++) begin
      in_flight = in_flight | (|pipe[s]);
    end
  end

  assign busy = (|req) | in_flight;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ARB;
      rr_ptr <= '0;
      owner  <= '0;
      for (int s = 0; s < RD_LATENCY; s++) begin
        pipe[s] <= '0;
      end
    end else begin
      pipe[0] <= req & gnt;
      for (int s = 1; s < RD_LATENCY; s++) begin
        pipe[s] <= pipe[s-1];
      end
      case (state)
        ARB: begin
          if (accept) begin
            if (lock[pick_idx]) begin
              state <= LOCKED;
              owner <= pick_idx;
            end else begin
              rr_ptr <= PTR_W'(wrap_inc(int'(pick_idx), NUM_REQ));
            end
          end
        end
        LOCKED: begin
          // Release on an unlocked accept or when the owner stops asking.
          if (!req[owner] || !lock[owner]) begin
            state  <= ARB;
            rr_ptr <= PTR_W'(wrap_inc(int'(owner), NUM_REQ));
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_bram_read_arbiter.sv
// Directed bench for conv_bram_read_arbiter with a 2-cycle BRAM model and an
// expected-return queue checked every cycle.
module tb_conv_bram_read_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req = '0;
  logic [3:0]   lock = '0;
  logic [47:0]  req_addr = '0;
  logic [3:0]   gnt;
  logic [3:0]   rd_valid;
  logic [255:0] rd_data;
  logic [11:0]  bram_addr;
  logic         bram_en;
  logic [255:0] bram_dout;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [11:0]  ra [4] = '{default: '0};
  logic [15:0]  exp_q [$];
  int           due_q [$];
  logic [15:0]  mon_e;
  logic [3:0]   pend = '0;
  logic [11:0]  prev_addr [4] = '{default: '0};
  logic [255:0] s1 = '0;
  logic [255:0] s2 = '0;

  conv_bram_read_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .lock      (lock),
    .req_addr  (req_addr),
    .gnt       (gnt),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .bram_addr (bram_addr),
    .bram_en   (bram_en),
    .bram_dout (bram_dout),
    .busy      (busy)
  );

  // clock / reset block
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [255:0] word(input logic [11:0] a);
    logic [255:0] w;
    for (int k = 0; k < 8; k++) w[k*32 +: 32] = {a, 4'(k), 16'hBEEF};
    return w;
  endfunction

  function automatic int oh_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  // BRAM_PS model with two cycles of read latency.
  always @(posedge clk) begin
    if (bram_en) s1 <= word(bram_addr);
    s2 <= s1;
  end
  assign bram_dout = s2;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // driver tasks
  task automatic drive_addr();
    for (int i = 0; i < 4; i++) req_addr[i*12 +: 12] = ra[i];
  endtask

  task automatic step(input string tag, input logic [3:0] r, input logic [3:0] l,
                      input logic [3:0] eg, input logic eb);
    req = r;
    lock = l;
    drive_addr();
    #3;
    check({tag, "_gnt"}, gnt, eg);
    check({tag, "_en"}, bram_en, |eg);
    check({tag, "_addr"}, bram_addr, (eg != 0) ? ra[oh_idx(eg)] : 12'h000);
    check({tag, "_busy"}, busy, eb);
    if (eg != 0) begin
      exp_q.push_back({eg, ra[oh_idx(eg)]});
      due_q.push_back(cyc + 2);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rst_step(input logic [3:0] r);
    rst = 1'b1;
    req = r;
    lock = '0;
    drive_addr();
    exp_q.delete();
    due_q.delete();
    #3;
    check("rst_gnt", gnt, 4'b0000);
    check("rst_en", bram_en, 1'b0);
    check("rst_addr", bram_addr, 12'h000);
    @(posedge clk);
    #1;
  endtask

  // scoreboard: return path and request-protocol monitor
  always @(negedge clk) begin
    if (rst) begin
      check("rd_valid_rst", rd_valid, '0);
    end else if (due_q.size() > 0 && due_q[0] == cyc) begin
      mon_e = exp_q.pop_front();
      void'(due_q.pop_front());
      check("rd_valid", rd_valid, mon_e[15:12]);
      check("rd_data", rd_data, word(mon_e[11:0]));
    end else begin
      check("rd_valid_idle", rd_valid, '0);
    end
    for (int i = 0; i < 4; i++) begin
      if (pend[i] && req[i]) check("proto_addr", req_addr[i*12 +: 12], prev_addr[i]);
      pend[i] = req[i] & ~gnt[i];
      prev_addr[i] = req_addr[i*12 +: 12];
    end
  end

  initial begin
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) rst_step(4'b0000);
    rst = 1'b0;
    step("reset_idle", 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // single engine, data returns two cycles later
    ra[0] = 12'h005;
    step("t1_acc", 4'b0001, 4'b0000, 4'b0001, 1'b1);
    step("t1_fl1", 4'b0000, 4'b0000, 4'b0000, 1'b1);
    step("t1_fl2", 4'b0000, 4'b0000, 4'b0000, 1'b1);
    step("t1_done", 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // all request, unlocked: rr_ptr starts at 1
    ra[0] = 12'h100; ra[1] = 12'h101; ra[2] = 12'h102; ra[3] = 12'h103;
    step("t2_0", 4'b1111, 4'b0000, 4'b0010, 1'b1);
    step("t2_1", 4'b1111, 4'b0000, 4'b0100, 1'b1);
    step("t2_2", 4'b1111, 4'b0000, 4'b1000, 1'b1);
    step("t2_3", 4'b1111, 4'b0000, 4'b0001, 1'b1);
    step("t2_4", 4'b1111, 4'b0000, 4'b0010, 1'b1);
    step("t2_5", 4'b1111, 4'b0000, 4'b0100, 1'b1);
    step("t2_6", 4'b1111, 4'b0000, 4'b1000, 1'b1);
    step("t2_7", 4'b1111, 4'b0000, 4'b0001, 1'b1);
    step("t2_8", 4'b1111, 4'b0000, 4'b0010, 1'b1);
    step("t2_d0", 4'b0000, 4'b0000, 4'b0000, 1'b1);
    step("t2_d1", 4'b0000, 4'b0000, 4'b0000, 1'b1);

    // burst lock by engine 2 for five accepts, then engine 3, then 0
    for (int k = 0; k < 5; k++) begin
      ra[2] = 12'h010 + 12'(k);
      step("t3_lock", 4'b1111, (k < 4) ? 4'b0100 : 4'b0000, 4'b0100, 1'b1);
    end
    step("t3_after", 4'b1011, 4'b0000, 4'b1000, 1'b1);
    step("t3_next", 4'b1011, 4'b0000, 4'b0001, 1'b1);
    step("t3_d0", 4'b0000, 4'b0000, 4'b0000, 1'b1);
    step("t3_d1", 4'b0000, 4'b0000, 4'b0000, 1'b1);

    // lock holder drops req: dead cycle, then resume at owner+1
    ra[0] = 12'h040; ra[1] = 12'h020; ra[3] = 12'h030;
    step("t4_lock", 4'b0010, 4'b0010, 4'b0010, 1'b1);
    step("t4_drop", 4'b1001, 4'b0000, 4'b0000, 1'b1);
    step("t4_resume", 4'b1001, 4'b0000, 4'b1000, 1'b1);
    step("t4_last", 4'b0001, 4'b0000, 4'b0001, 1'b1);
    step("t4_d0", 4'b0000, 4'b0000, 4'b0000, 1'b1);
    step("t4_d1", 4'b0000, 4'b0000, 4'b0000, 1'b1);

    // reset discards in-flight reads and the lock
    ra[0] = 12'h050; ra[1] = 12'h060;
    step("t5_e1", 4'b0011, 4'b0000, 4'b0010, 1'b1);
    step("t5_e0", 4'b0011, 4'b0001, 4'b0001, 1'b1);
    rst_step(4'b0010);
    rst_step(4'b0010);
    rst = 1'b0;
    step("t5_post", 4'b0010, 4'b0000, 4'b0010, 1'b1);
    step("t5_d0", 4'b0000, 4'b0000, 4'b0000, 1'b1);
    step("t5_d1", 4'b0000, 4'b0000, 4'b0000, 1'b1);

    // long idle keeps rr_ptr at 2
    for (int k = 0; k < 100; k++) step("t6_idle", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    ra[0] = 12'h070; ra[3] = 12'h080;
    step("t6_wake", 4'b1001, 4'b0000, 4'b1000, 1'b1);
    step("t6_d0", 4'b0000, 4'b0000, 4'b0000, 1'b1);
    step("t6_d1", 4'b0000, 4'b0000, 4'b0000, 1'b1);
    step("t6_d2", 4'b0000, 4'b0000, 4'b0000, 1'b0);

    check("q_empty", 256'(exp_q.size()), 256'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
